// File: rtl/axi_cmd_pkg.sv
// Shared definitions for the single-outstanding AXI command manager.
//  - state_e       : manager FSM states
//  - resp_t        : AXI BRESP/RRESP encoding plus the two codes the manager generates itself
//  - cnt_width()   : bit width needed to count up to a given limit (at least 1 bit)
package axi_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_B,
        RD_A,
        RD_D,
        RSP
    } state_e;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    localparam int TIMEOUT_CYC_DEFAULT = 255;

    function automatic int cnt_width(input int max_count);
        if (max_count < 2) begin
            return 1;
        end
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/axi_cmd_manager_if.sv
// Single-beat AXI bus between the command manager (master modport) and a
// subordinate (slave modport). Carries the AW, W, B, AR and R channels.
//  Parameters: DATA_WIDTH (wdata/rdata), ADDR_WIDTH (awaddr/araddr)
interface axi_cmd_manager_if
    import axi_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) ();

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic                  wlast;

    resp_t                 bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    resp_t                 rresp;
    logic                  rvalid;
    logic                  rready;
    logic                  rlast;

    modport master (
        output awaddr, awvalid, wdata, wvalid, wlast, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid, rlast
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, wlast, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid, rlast
    );

endinterface

// File: rtl/axi_timeout_cnt.sv
// Saturating watchdog counter.
//  clk, rst_n : clock, asynchronous active-low reset
//  clear      : force count to zero (has priority over enable)
//  enable     : count up by one per cycle, stopping at MAX_COUNT
//  expired    : count has reached MAX_COUNT while enabled; never set when MAX_COUNT is 0
module axi_timeout_cnt
    import axi_cmd_pkg::*;
#(
    parameter int MAX_COUNT = TIMEOUT_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            W     = cnt_width(MAX_COUNT);
    localparam logic [W-1:0]  LIMIT = W'(MAX_COUNT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A limit of zero means the watchdog is switched off.
    assign expired = (MAX_COUNT != 0) && enable && (cnt_q == LIMIT);

endmodule

// File: rtl/axi_cmd_manager.sv
// Single-outstanding AXI manager: turns a simple command/response handshake into
// one single-beat AXI write (AW/W/B) or read (AR/R) and returns data/status.
// A watchdog aborts a transaction the subordinate never finishes.
//  s_axi_clk, s_axi_resetn : clock, asynchronous active-low reset
//  cmd_*                   : command in (valid/ready, write, addr, wdata)
//  rsp_*                   : response out (valid/ready, rdata, resp, timeout)
//  m_axi                   : AXI master port (all outputs registered)
module axi_cmd_manager
    import axi_cmd_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                  s_axi_clk,
    input  logic                  s_axi_resetn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output resp_t                 rsp_resp,
    output logic                  rsp_timeout,

    axi_cmd_manager_if.master     m_axi
);

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  arvalid_q, arvalid_d;
    logic                  bready_q, bready_d;
    logic                  rready_q, rready_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    resp_t                 rsp_resp_q, rsp_resp_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic                  cmd_accept;
    logic                  busy;
    logic                  expired;
    logic                  abort;

    // cmd_ready_q is only ever set in IDLE, so it alone qualifies the accept.
    assign cmd_accept = cmd_valid && cmd_ready_q;
    assign busy       = (state_q == WR) || (state_q == WR_B) ||
                        (state_q == RD_A) || (state_q == RD_D);

    axi_timeout_cnt #(
        .MAX_COUNT (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (s_axi_clk),
        .rst_n   (s_axi_resetn),
        .clear   (cmd_accept),
        .enable  (busy),
        .expired (expired)
    );

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        abort         = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_accept) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    if (cmd_write) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RD_A;
                        arvalid_d = 1'b1;
                    end
                end
            end

            WR: begin
                // AW and W retire independently, in any order or together.
                if (awvalid_q && m_axi.awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && m_axi.wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d  = WR_B;
                    bready_d = 1'b1;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end

            WR_B: begin
                if (m_axi.bvalid) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = m_axi.bresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end

            RD_A: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_D;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end

            RD_D: begin
                if (m_axi.rvalid) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = m_axi.rdata;
                    // A single-beat read must be the last beat; anything else is an error.
                    rsp_resp_d    = m_axi.rlast ? m_axi.rresp : RESP_SLVERR;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog abort: withdraw every AXI valid/ready and report an error.
        if (abort) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            bready_d      = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = RESP_SLVERR;
            rsp_timeout_d = 1'b1;
            state_d       = RSP;
        end
    end

    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_OKAY;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.wlast   = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

endmodule
